// File: rtl/brick_game_pkg.sv
// Shared types and constants for the brick game driver: FSM states, LFSR
// defaults and the row/hit/count field widths used by driver and bench.
package brick_game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } state_t;

    localparam int          NUM_ROWS          = 8;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    // Taps x^16 + x^14 + x^13 + x^11 map to state bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;

    localparam int ROW_W = 8;
    localparam int HIT_W = 6;
    localparam int CNT_W = 7;

endpackage

// File: rtl/brick_game_driver_lfsr16.sv
// 16-bit Fibonacci LFSR that shifts left with the feedback bit entering bit 0.
// A load takes priority over a step.
module lfsr16
    import brick_game_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAP_MASK);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/brick_game_driver.sv
// Plays one brick game: streams 8 LFSR-generated rows to the game core, then
// waits (bounded by TIMEOUT_CYC) for the destroyed-brick count.
module brick_game_driver
    import brick_game_pkg::*;
#(
    parameter int TIMEOUT_CYC = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      seed,
    output logic             busy,
    output logic [ROW_W-1:0] in,
    output logic [ROW_W-1:0] bomb,
    output logic [HIT_W-1:0] hit,
    output logic             in_valid1,
    output logic             in_valid2,
    input  logic             out_valid,
    input  logic [CNT_W-1:0] out,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             timeout
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
    localparam logic [2:0] LAST_ROW    = 3'(NUM_ROWS - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  row_cnt;
    logic [7:0]  wait_cnt;
    logic [15:0] lfsr_q;
    logic        lfsr_load;
    logic        wait_expired;

    assign lfsr_load    = (state == IDLE) && start;
    assign wait_expired = (wait_cnt == TIMEOUT_LIM);

    lfsr16 u_lfsr (
        .clk  (clk),
        .load (lfsr_load),
        .seed ((seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed),
        .step (state == SEND),
        .q    (lfsr_q)
    );

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        in_valid1  = (state == SEND);
        in_valid2  = (state == SEND);
        done       = (state == DONE);
        in         = '0;
        bomb       = '0;
        hit        = '0;
        if (state == SEND) begin
            in   = lfsr_q[7:0];
            bomb = lfsr_q[15:8];
            hit  = lfsr_q[5:0] ^ lfsr_q[13:8];
        end
        case (state)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (row_cnt == LAST_ROW) state_next = WAIT;
            WAIT:    if (out_valid || wait_expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            wait_cnt <= '0;
            result   <= '0;
            timeout  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt <= '0;
                        result  <= '0;
                        timeout <= 1'b0;
                    end
                end
                SEND: begin
                    row_cnt <= row_cnt + 3'd1;
                    if (row_cnt == LAST_ROW) wait_cnt <= '0;
                end
                WAIT: begin
                    // A response in the expiry cycle wins over the timeout.
                    if (out_valid) begin
                        result  <= out;
                        timeout <= 1'b0;
                    end else if (wait_expired) begin
                        result  <= '0;
                        timeout <= 1'b1;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_game_driver.sv
// Directed bench for brick_game_driver: row stream, response/timeout paths,
// mid-game reset, held start with stray strobes, and a behavioural game core.
module tb_brick_game_driver;
    import brick_game_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic        busy;
    logic [7:0]  in;
    logic [7:0]  bomb;
    logic [5:0]  hit;
    logic        in_valid1;
    logic        in_valid2;
    logic        out_valid;
    logic [6:0]  out;
    logic        done;
    logic [6:0]  result;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    brick_game_driver #(.TIMEOUT_CYC(63)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .in        (in),
        .bomb      (bomb),
        .hit       (hit),
        .in_valid1 (in_valid1),
        .in_valid2 (in_valid2),
        .out_valid (out_valid),
        .out       (out),
        .done      (done),
        .result    (result),
        .timeout   (timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Game rules: each hit on a live brick destroys it; if that cell also holds
    // a bomb, every live brick in the same row is destroyed as well.
    function automatic logic [6:0] score_game(input logic [63:0] bricks,
                                              input logic [63:0] bombs,
                                              input logic [47:0] hits);
        logic [63:0] b;
        logic [5:0]  h;
        int          cnt;
        b   = bricks;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            h = hits[k*6 +: 6];
            if (b[h]) begin
                if (bombs[h]) begin
                    cnt += $countones(b[h[5:3]*8 +: 8]);
                    b[h[5:3]*8 +: 8] = 8'h00;
                end else begin
                    cnt += 1;
                    b[h] = 1'b0;
                end
            end
        end
        return 7'(cnt);
    endfunction

    task automatic start_game(input logic [15:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; out_valid = 1'b0; out = '0; seed = '0;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (in !== 8'h00) begin bad++; $display("FAIL reset_in got=%0h exp=0", in); end
        total++; if (bomb !== 8'h00) begin bad++; $display("FAIL reset_bomb got=%0h exp=0", bomb); end
        total++; if (hit !== 6'h00) begin bad++; $display("FAIL reset_hit got=%0h exp=0", hit); end
        total++; if (in_valid1 !== 1'b0 || in_valid2 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b%0b exp=00", in_valid1, in_valid2); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (result !== 7'd0) begin bad++; $display("FAIL reset_result got=%0d exp=0", result); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rows_and_response;
        logic [15:0] x;
        start_game(16'h0000);
        total++; if (in !== 8'hE1 || bomb !== 8'hAC || hit !== 6'h0D) begin bad++; $display("FAIL first_row got=%0h/%0h/%0h exp=e1/ac/d", in, bomb, hit); end
        x = LFSR_DEFAULT_SEED;
        for (int r = 0; r < 8; r++) begin
            total++; if (in_valid1 !== 1'b1 || in_valid2 !== 1'b1) begin bad++; $display("FAIL row%0d_valid got=%0b%0b exp=11", r, in_valid1, in_valid2); end
            total++; if (in !== x[7:0] || bomb !== x[15:8]) begin bad++; $display("FAIL row%0d_data got=%0h/%0h exp=%0h/%0h", r, in, bomb, x[7:0], x[15:8]); end
            total++; if (hit !== (x[5:0] ^ x[13:8])) begin bad++; $display("FAIL row%0d_hit got=%0h exp=%0h", r, hit, x[5:0] ^ x[13:8]); end
            x = model_next(x);
            tick();
        end
        total++; if (in_valid1 !== 1'b0 || in !== 8'h00 || bomb !== 8'h00 || hit !== 6'h00) begin bad++; $display("FAIL wait_idle_bus got=%0b/%0h/%0h/%0h exp=0/0/0/0", in_valid1, in, bomb, hit); end
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL wait_busy got=%0b/%0b exp=1/0", busy, done); end
        tick();
        tick();
        out_valid = 1'b1; out = 7'd23;
        tick();
        out_valid = 1'b0; out = 7'd0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL resp_done got=%0b exp=1", done); end
        total++; if (result !== 7'd23 || timeout !== 1'b0) begin bad++; $display("FAIL resp_result got=%0d/%0b exp=23/0", result, timeout); end
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0 || result !== 7'd23) begin bad++; $display("FAIL resp_after got=%0b/%0b/%0d exp=0/0/23", busy, done, result); end
    endtask

    task automatic test_timeout;
        int n;
        start_game(16'h5A5A);
        total++; if (result !== 7'd0 || timeout !== 1'b0) begin bad++; $display("FAIL start_clears got=%0d/%0b exp=0/0", result, timeout); end
        for (int r = 0; r < 8; r++) tick();
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        total++; if (n != 64) begin bad++; $display("FAIL timeout_latency got=%0d exp=64", n); end
        total++; if (timeout !== 1'b1 || result !== 7'd0) begin bad++; $display("FAIL timeout_flags got=%0b/%0d exp=1/0", timeout, result); end
        tick();
        total++; if (timeout !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_held got=%0b/%0b exp=1/0", timeout, busy); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] x;
        int          dcount;
        start_game(16'h00FF);
        for (int r = 0; r < 4; r++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0 || in_valid1 !== 1'b0 || in_valid2 !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%0b%0b%0b%0b exp=0000", busy, in_valid1, in_valid2, done); end
        total++; if (in !== 8'h00 || bomb !== 8'h00 || hit !== 6'h00) begin bad++; $display("FAIL midrst_bus got=%0h/%0h/%0h exp=0/0/0", in, bomb, hit); end
        total++; if (result !== 7'd0 || timeout !== 1'b0) begin bad++; $display("FAIL midrst_regs got=%0d/%0b exp=0/0", result, timeout); end
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL midrst_quiet got=%0d exp=0", dcount); end
        start_game(16'h00FF);
        x = 16'h00FF;
        for (int r = 0; r < 8; r++) begin
            total++; if (in_valid1 !== 1'b1 || in !== x[7:0] || bomb !== x[15:8] || hit !== (x[5:0] ^ x[13:8])) begin bad++; $display("FAIL restart_row%0d got=%0b/%0h/%0h/%0h exp=1/%0h/%0h/%0h", r, in_valid1, in, bomb, hit, x[7:0], x[15:8], x[5:0] ^ x[13:8]); end
            x = model_next(x);
            tick();
        end
        out_valid = 1'b1; out = 7'd5;
        tick();
        out_valid = 1'b0; out = 7'd0;
        total++; if (done !== 1'b1 || result !== 7'd5) begin bad++; $display("FAIL earliest_done got=%0b/%0d exp=1/5", done, result); end
        tick();
    endtask

    task automatic test_back_to_back;
        int vcount;
        int dcount;
        vcount = 0;
        dcount = 0;
        seed  = 16'h0BEE;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (in_valid1 === 1'b1) vcount++;
            if (done === 1'b1) dcount++;
            if (c == 10) begin
                total++; if (done !== 1'b1 || result !== 7'd42) begin bad++; $display("FAIL b2b_game1 got=%0b/%0d exp=1/42", done, result); end
            end
            if (c == 11) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", busy); end
            end
            if (c == 12) begin
                total++; if (in_valid1 !== 1'b1 || in !== 8'hEE || bomb !== 8'h0B) begin bad++; $display("FAIL b2b_restart got=%0b/%0h/%0h exp=1/ee/b", in_valid1, in, bomb); end
            end
            if (c == 21) begin
                total++; if (done !== 1'b1 || result !== 7'd17) begin bad++; $display("FAIL b2b_game2 got=%0b/%0d exp=1/17", done, result); end
            end
            out_valid = (c == 2 || c == 5 || c == 13 || c == 16 || c == 9 || c == 20);
            out = (c == 9) ? 7'd42 : (c == 20) ? 7'd17 : 7'd99;
            start = (c < 21);
        end
        out_valid = 1'b0; out = 7'd0; start = 1'b0;
        total++; if (vcount != 16) begin bad++; $display("FAIL b2b_rows got=%0d exp=16", vcount); end
        total++; if (dcount != 2) begin bad++; $display("FAIL b2b_games got=%0d exp=2", dcount); end
        total++; if (busy !== 1'b0 || result !== 7'd17) begin bad++; $display("FAIL b2b_end got=%0b/%0d exp=0/17", busy, result); end
    endtask

    task automatic test_game_core;
        logic [63:0] cap_bricks, cap_bombs, gold_bricks, gold_bombs;
        logic [47:0] cap_hits, gold_hits;
        logic [15:0] x;
        logic [6:0]  core_score, gold_score;
        x = 16'h1234;
        for (int r = 0; r < 8; r++) begin
            gold_bricks[r*8 +: 8] = x[7:0];
            gold_bombs[r*8 +: 8]  = x[15:8];
            gold_hits[r*6 +: 6]   = x[5:0] ^ x[13:8];
            x = model_next(x);
        end
        gold_score = score_game(gold_bricks, gold_bombs, gold_hits);
        cap_bricks = '0; cap_bombs = '0; cap_hits = '0;
        start_game(16'h1234);
        for (int r = 0; r < 8; r++) begin
            if (in_valid1 === 1'b1) begin
                cap_bricks[r*8 +: 8] = in;
                cap_bombs[r*8 +: 8]  = bomb;
            end
            if (in_valid2 === 1'b1) cap_hits[r*6 +: 6] = hit;
            tick();
        end
        core_score = score_game(cap_bricks, cap_bombs, cap_hits);
        tick();
        tick();
        out_valid = 1'b1; out = core_score;
        tick();
        out_valid = 1'b0; out = 7'd0;
        total++; if (done !== 1'b1 || result !== gold_score) begin bad++; $display("FAIL core_result got=%0b/%0d exp=1/%0d", done, result, gold_score); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rows_and_response();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_game_core();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brick_game_driver.md
BRICK_GAME_DRIVER -- requirements
Module: brick_game_driver

Interface
REQ-001 Parameter TIMEOUT_CYC, default 63: maximum cycles spent waiting for a response before aborting.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request to play one game; honoured only in IDLE.
REQ-005 seed  input  16  LFSR seed, sampled with start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 in  output  8  brick row to game core; bit i of row r is cell r*8+i.
REQ-008 bomb  output  8  bomb row, same cell mapping as in.
REQ-009 hit  output  6  hit cell index 0..63.
REQ-010 in_valid1  output  1  qualifies in and bomb.
REQ-011 in_valid2  output  1  qualifies hit.
REQ-012 out_valid  input  1  game core result strobe.
REQ-013 out  input  7  game core destroyed-brick count.
REQ-014 done  output  1  one-cycle pulse at game completion.
REQ-015 result  output  7  captured count, held until the next start.
REQ-016 timeout  output  1  set at completion if no response arrived; held until the next start.

Function
REQ-017 FSM states: IDLE, SEND, WAIT, DONE.
REQ-018 IDLE -> SEND on start; seed is loaded into the LFSR, or 16'hACE1 if seed==0; result and timeout clear.
REQ-019 SEND lasts exactly 8 cycles (row counter 0..7); in_valid1 and in_valid2 are both high on every SEND cycle.
REQ-020 Each SEND cycle drives in=lfsr[7:0], bomb=lfsr[15:8], hit=lfsr[5:0]^lfsr[13:8], then advances the LFSR one step.
REQ-021 LFSR is 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left with the feedback bit entering bit 0.
REQ-022 Outputs in, bomb, and hit are driven 0 whenever in_valid1/in_valid2 are low.
REQ-023 SEND -> WAIT after row 7; the wait counter clears on entry.
REQ-024 WAIT: out_valid==1 captures out into result -> DONE, with timeout=0.
REQ-025 WAIT: if the wait counter reaches TIMEOUT_CYC without out_valid -> DONE with result=0 and timeout=1; out_valid and timeout in the same cycle resolves as response, not timeout.
REQ-026 Wait counter width is 8 bits, saturating; TIMEOUT_CYC above 255 is illegal.
REQ-027 DONE lasts one cycle, pulses done, then -> IDLE.
REQ-028 out_valid outside WAIT is ignored; start outside IDLE is ignored, including start asserted together with done.
REQ-029 Latency: start at cycle 0, first row at cycle 1, last row at cycle 8, earliest done at cycle 10.

Reset
REQ-030 rst forces IDLE; busy, in, bomb, hit, in_valid1, in_valid2, done, result, and timeout are all 0 and the counters are 0 after the edge.
REQ-031 rst mid-SEND or mid-WAIT aborts the game on the next edge with no done pulse; a partial row stream is acceptable to the core because its own FSM restarts.

Structure
REQ-032 Shared package brick_game_pkg holds: state enum, NUM_ROWS=8, LFSR_DEFAULT_SEED=16'hACE1, LFSR tap mask, and the row/hit/count widths (8/6/7).
REQ-033 One sub-module, lfsr16, with ports load, seed, step, and q; everything else stays in the top module.

Verification
REQ-034 seed=0, start -> cycle 1: in=8'hE1, bomb=8'hAC, hit=6'h0D, in_valid1=in_valid2=1; exactly 8 valid cycles follow.
REQ-035 Responder model asserts out_valid with out=7'd23 three cycles after the last row -> done pulse one cycle later, result=23, timeout=0, busy low the cycle after done.
REQ-036 No out_valid ever, TIMEOUT_CYC=63 -> done exactly 64 cycles after WAIT entry, timeout=1, result=0.
REQ-037 rst asserted on SEND row 4 -> next cycle all outputs are 0 and no done pulse; a fresh start with the same seed reproduces the identical row stream.
REQ-038 start held high continuously across a full game plus stray out_valid pulses during SEND -> exactly one game per IDLE visit and result is unaffected by the stray pulses.
REQ-039 Connected to the game core with seed=16'h1234 -> result equals the value from the bench golden model of the bomb/brick rules.
